// File: rtl/eth_ctrl_pkg.sv
// Shared definitions for the Ethernet port bring-up controller.
package eth_ctrl_pkg;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        PS_OFF    = ST_OFF,
        PS_ASSERT = ST_ASSERT,
        PS_WAIT   = ST_WAIT,
        PS_RUN    = ST_RUN
    } port_state_e;

    // Largest of three cycle counts; sizes the shared per-port down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eth_port_seq.sv
// One port's reset sequencer, link debounce and link-drop counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OFF    | port disabled or PLL unlocked; PHY and MAC held in reset
// ASSERT | PHY reset pulse in progress; MAC held in reset
// WAIT   | PHY released, settling before MAC release
// RUN    | both out of reset; link debounce active
module eth_port_seq
    import eth_ctrl_pkg::*;
#(
    parameter int RstPulseCycles = 500_000,
    parameter int RstWaitCycles  = 2_500_000,
    parameter int DebounceCycles = 50_000,
    parameter bit AutoRestart    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  en,
    input  logic                  restart,
    input  logic                  lnk,
    output logic                  phy_rst_n,
    output logic                  mac_rst_n,
    output logic                  link_up,
    output logic                  set_10,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int CntW = $clog2(max3(RstPulseCycles, RstWaitCycles, DebounceCycles) + 1);

    // The counter runs down to zero, so each load is one less than the length.
    localparam logic [CntW-1:0] PulseLoad = CntW'(RstPulseCycles - 1);
    localparam logic [CntW-1:0] WaitLoad  = CntW'(RstWaitCycles - 1);
    localparam logic [CntW-1:0] DebLoad   = CntW'(DebounceCycles - 1);

    port_state_e     state;
    logic [CntW-1:0] cnt;
    logic            cnt_tc;
    logic            restart_ok;
    logic            deb_done;
    logic            auto_fall;
    logic            link_fall;

    assign cnt_tc     = (cnt == '0);
    assign restart_ok = restart && (state == PS_WAIT || state == PS_RUN);
    assign deb_done   = (state == PS_RUN) && (lnk != link_up) && cnt_tc;
    assign auto_fall  = AutoRestart && deb_done && link_up;
    // link_up is only ever 1 in RUN, so any exit from RUN or a debounced
    // loss while link_up=1 is a drop.
    assign link_fall  = link_up && (!lock || !en || restart_ok || deb_done);

    assign set_10 = link_up & ~lnk;

    // Port FSM with registered reset outputs, shared down-counter and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PS_OFF;
            cnt       <= '0;
            phy_rst_n <= 1'b0;
            mac_rst_n <= 1'b0;
            link_up   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (!lock || !en) begin
                state     <= PS_OFF;
                cnt       <= '0;
                phy_rst_n <= 1'b0;
                mac_rst_n <= 1'b0;
                link_up   <= 1'b0;
            end else if (restart_ok || auto_fall) begin
                state     <= PS_ASSERT;
                cnt       <= PulseLoad;
                phy_rst_n <= 1'b0;
                mac_rst_n <= 1'b0;
                link_up   <= 1'b0;
            end else begin
                case (state)
                    PS_OFF: begin
                        state     <= PS_ASSERT;
                        cnt       <= PulseLoad;
                        phy_rst_n <= 1'b0;
                        mac_rst_n <= 1'b0;
                        link_up   <= 1'b0;
                    end
                    PS_ASSERT: begin
                        if (cnt_tc) begin
                            state     <= PS_WAIT;
                            cnt       <= WaitLoad;
                            phy_rst_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PS_WAIT: begin
                        if (cnt_tc) begin
                            state     <= PS_RUN;
                            cnt       <= DebLoad;
                            mac_rst_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PS_RUN: begin
                        if (lnk == link_up) begin
                            cnt <= DebLoad;
                        end else if (cnt_tc) begin
                            link_up <= lnk;
                            cnt     <= DebLoad;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= PS_OFF;
                        cnt   <= '0;
                    end
                endcase
            end

            if (link_fall && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/signal_sync.sv
// Multi-flop synchroniser for asynchronous level inputs, reset to 0.
module signal_sync #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Depth-1:0][Width-1:0] stages;

    // Shift the raw input through Depth flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[Depth-2:0], d};
        end
    end

    assign q = stages[Depth-1];

endmodule

// File: rtl/eth_port_ctrl.sv
// Multi-port PHY/MAC bring-up controller: input synchronisers plus one
// sequencer per port.
module eth_port_ctrl
    import eth_ctrl_pkg::*;
#(
    parameter int NumPorts       = 2,
    parameter int RstPulseCycles = 500_000,
    parameter int RstWaitCycles  = 2_500_000,
    parameter int DebounceCycles = 50_000,
    parameter bit AutoRestart    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pll_locked_i,
    input  logic [NumPorts-1:0]            port_en_i,
    input  logic [NumPorts-1:0]            restart_i,
    input  logic [NumPorts-1:0]            link100_i,
    output logic [NumPorts-1:0]            phy_rst_n_o,
    output logic [NumPorts-1:0]            mac_rst_n_o,
    output logic [NumPorts-1:0]            link_up_o,
    output logic [NumPorts-1:0]            set_10_o,
    output logic [NumPorts-1:0]            set_1000_o,
    output logic [DROP_CNT_W*NumPorts-1:0] link_drop_cnt_o
);

    logic                lock_s;
    logic [NumPorts-1:0] en_s;
    logic [NumPorts-1:0] lnk_s;

    signal_sync #(.Width(1), .Depth(2)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    signal_sync #(.Width(NumPorts), .Depth(2)) u_en_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (port_en_i),
        .q     (en_s)
    );

    signal_sync #(.Width(NumPorts), .Depth(2)) u_lnk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link100_i),
        .q     (lnk_s)
    );

    // The PHYs are 10/100 only, so gigabit mode is never selected.
    assign set_1000_o = '0;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        eth_port_seq #(
            .RstPulseCycles (RstPulseCycles),
            .RstWaitCycles  (RstWaitCycles),
            .DebounceCycles (DebounceCycles),
            .AutoRestart    (AutoRestart)
        ) u_seq (
            .clk       (clk),
            .rst_n     (rst_n),
            .lock      (lock_s),
            .en        (en_s[p]),
            .restart   (restart_i[p]),
            .lnk       (lnk_s[p]),
            .phy_rst_n (phy_rst_n_o[p]),
            .mac_rst_n (mac_rst_n_o[p]),
            .link_up   (link_up_o[p]),
            .set_10    (set_10_o[p]),
            .drop_cnt  (link_drop_cnt_o[DROP_CNT_W*p +: DROP_CNT_W])
        );
    end

endmodule

// File: tb/tb_eth_port_ctrl.sv
// Self-checking bench for eth_port_ctrl (2 ports, 4/6/3 cycle timing).
module tb_eth_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked_i = 1'b0;
    logic [1:0]  port_en_i = 2'b00;
    logic [1:0]  restart_i = 2'b00;
    logic [1:0]  link100_i = 2'b00;
    logic [1:0]  phy_rst_n_o, mac_rst_n_o, link_up_o, set_10_o, set_1000_o;
    logic [15:0] link_drop_cnt_o;

    int n_checks = 0;
    int n_passed = 0;

    typedef struct {
        string      name;
        int         port;
        int         k;
        logic [3:0] bits;   // {phy_rst_n, mac_rst_n, link_up, set_10}
    } exp_t;

    exp_t sb[$];
    int   drop_q[$];

    eth_port_ctrl #(
        .NumPorts       (2),
        .RstPulseCycles (4),
        .RstWaitCycles  (6),
        .DebounceCycles (3),
        .AutoRestart    (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked_i    (pll_locked_i),
        .port_en_i       (port_en_i),
        .restart_i       (restart_i),
        .link100_i       (link100_i),
        .phy_rst_n_o     (phy_rst_n_o),
        .mac_rst_n_o     (mac_rst_n_o),
        .link_up_o       (link_up_o),
        .set_10_o        (set_10_o),
        .set_1000_o      (set_1000_o),
        .link_drop_cnt_o (link_drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs k sample-cycles after stimulus, for a port that enters
    // ASSERT at sample a with the link input held at lk throughout.
    function automatic logic [3:0] seq_exp(input int k, input int a, input bit lk);
        logic [3:0] r;
        r[3] = (k >= a + 4);
        r[2] = (k >= a + 10);
        r[1] = lk && (k >= a + 13);
        r[0] = 1'b0;
        return r;
    endfunction

    task automatic push_exp(input string name, input int p, input int k, input logic [3:0] b);
        exp_t e;
        e.name = name;
        e.port = p;
        e.k    = k;
        e.bits = b;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pll_locked_i = 1'b0;
        port_en_i = 2'b00;
        restart_i = 2'b00;
        link100_i = 2'b00;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bring_up();
        do_reset();
        pll_locked_i = 1'b1;
        port_en_i = 2'b11;
        link100_i = 2'b11;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (phy_rst_n_o !== 2'b00) $display("FAIL reset_phy got=%b exp=00", phy_rst_n_o); else n_passed++;
        n_checks++; if (mac_rst_n_o !== 2'b00) $display("FAIL reset_mac got=%b exp=00", mac_rst_n_o); else n_passed++;
        n_checks++; if (link_up_o !== 2'b00) $display("FAIL reset_link got=%b exp=00", link_up_o); else n_passed++;
        n_checks++; if (set_10_o !== 2'b00) $display("FAIL reset_set10 got=%b exp=00", set_10_o); else n_passed++;
        n_checks++; if (set_1000_o !== 2'b00) $display("FAIL reset_set1000 got=%b exp=00", set_1000_o); else n_passed++;
        n_checks++; if (link_drop_cnt_o !== 16'h0) $display("FAIL reset_drop got=%h exp=0000", link_drop_cnt_o); else n_passed++;
        // Asynchronous reset in the middle of a clock period while running.
        bring_up();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({phy_rst_n_o, mac_rst_n_o, link_up_o} !== 6'b0)
            $display("FAIL async_reset got=%b exp=000000", {phy_rst_n_o, mac_rst_n_o, link_up_o});
        else n_passed++;
    endtask

    task automatic test_powerup();
        exp_t e;
        logic [3:0] got;
        do_reset();
        pll_locked_i = 1'b1;
        port_en_i = 2'b11;
        link100_i = 2'b11;
        for (int k = 1; k <= 18; k++)
            for (int p = 0; p < 2; p++) push_exp("powerup", p, k, seq_exp(k, 3, 1'b1));
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
        end
        n_checks++; if (set_1000_o !== 2'b00) $display("FAIL powerup_set1000 got=%b exp=00", set_1000_o); else n_passed++;
        n_checks++; if (link_drop_cnt_o !== 16'h0) $display("FAIL powerup_drop got=%h exp=0000", link_drop_cnt_o); else n_passed++;
    endtask

    task automatic test_lock_loss();
        exp_t e;
        logic [3:0] got;
        logic [3:0] x;
        do_reset();
        pll_locked_i = 1'b1;
        port_en_i = 2'b11;
        link100_i = 2'b11;
        for (int k = 1; k <= 31; k++) begin
            if (k <= 10) x = seq_exp(k, 3, 1'b1);
            else if (k <= 16) x = 4'b0000;
            else x = seq_exp(k, 17, 1'b1);
            for (int p = 0; p < 2; p++) push_exp("lock_loss", p, k, x);
        end
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
            if (k == 8) pll_locked_i = 1'b0;
            if (k == 14) pll_locked_i = 1'b1;
        end
    endtask

    task automatic test_port_disable();
        exp_t e;
        logic [3:0] got;
        do_reset();
        pll_locked_i = 1'b1;
        port_en_i = 2'b01;
        link100_i = 2'b11;
        for (int k = 1; k <= 18; k++) begin
            push_exp("port_disable", 0, k, seq_exp(k, 3, 1'b1));
            push_exp("port_disable", 1, k, 4'b0000);
        end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
        end
    endtask

    task automatic test_link_glitch();
        exp_t e;
        logic [3:0] got;
        bring_up();
        // Two-cycle glitch: link stays up, set_10 reflects the raw low.
        link100_i[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push_exp("glitch", 0, k, (k == 2 || k == 3) ? 4'b1111 : 4'b1110);
            push_exp("glitch", 1, k, 4'b1110);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
            if (k == 2) link100_i[0] = 1'b1;
        end
        n_checks++; if (link_drop_cnt_o[7:0] !== 8'd0) $display("FAIL glitch_drop0 got=%0d exp=0", link_drop_cnt_o[7:0]); else n_passed++;
        // Sustained loss: debounced drop, counted, auto-restart into ASSERT.
        link100_i[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 1) push_exp("link_loss", 0, k, 4'b1110);
            else if (k <= 4) push_exp("link_loss", 0, k, 4'b1111);
            else push_exp("link_loss", 0, k, seq_exp(k, 5, 1'b0));
            push_exp("link_loss", 1, k, 4'b1110);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
        end
        n_checks++; if (link_drop_cnt_o[7:0] !== 8'd1) $display("FAIL loss_drop0 got=%0d exp=1", link_drop_cnt_o[7:0]); else n_passed++;
        n_checks++; if (link_drop_cnt_o[15:8] !== 8'd0) $display("FAIL loss_drop1 got=%0d exp=0", link_drop_cnt_o[15:8]); else n_passed++;
    endtask

    task automatic test_restart();
        exp_t e;
        logic [3:0] got;
        bring_up();
        // Single-cycle restart on port 0 while running.
        restart_i = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            push_exp("restart0", 0, k, seq_exp(k, 1, 1'b1));
            push_exp("restart0", 1, k, 4'b1110);
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
            if (k == 1) restart_i = 2'b00;
        end
        n_checks++; if (link_drop_cnt_o[7:0] !== 8'd1) $display("FAIL restart_drop0 got=%0d exp=1", link_drop_cnt_o[7:0]); else n_passed++;
        // Restart held on port 1: the samples taken in ASSERT must not extend it.
        restart_i = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            push_exp("restart1_hold", 0, k, 4'b1110);
            push_exp("restart1_hold", 1, k, seq_exp(k, 1, 1'b1));
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                e = sb.pop_front();
                got = {phy_rst_n_o[p], mac_rst_n_o[p], link_up_o[p], set_10_o[p]};
                n_checks++;
                if (got !== e.bits) $display("FAIL %s port%0d k=%0d got=%b exp=%b", e.name, e.port, e.k, got, e.bits);
                else n_passed++;
            end
            if (k == 3) restart_i = 2'b00;
        end
        n_checks++; if (link_drop_cnt_o[15:8] !== 8'd1) $display("FAIL restart_drop1 got=%0d exp=1", link_drop_cnt_o[15:8]); else n_passed++;
        n_checks++; if (link_drop_cnt_o[7:0] !== 8'd1) $display("FAIL restart_drop0_kept got=%0d exp=1", link_drop_cnt_o[7:0]); else n_passed++;
    endtask

    task automatic test_drop_saturation();
        int expd;
        bring_up();
        drop_q.delete();
        for (int i = 0; i < 300; i++) begin
            link100_i[0] = 1'b0;
            drop_q.push_back((i + 1 > 255) ? 255 : i + 1);
            repeat (6) @(negedge clk);
            link100_i[0] = 1'b1;
            repeat (15) @(negedge clk);
            expd = drop_q.pop_front();
            n_checks++;
            if (link_drop_cnt_o[7:0] !== expd[7:0])
                $display("FAIL drop_count iter=%0d got=%0d exp=%0d", i, link_drop_cnt_o[7:0], expd);
            else n_passed++;
        end
        n_checks++; if (link_drop_cnt_o[15:8] !== 8'd0) $display("FAIL sat_drop1 got=%0d exp=0", link_drop_cnt_o[15:8]); else n_passed++;
        n_checks++; if (link_up_o !== 2'b11) $display("FAIL sat_link_up got=%b exp=11", link_up_o); else n_passed++;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_lock_loss();
        test_port_disable();
        test_link_glitch();
        test_restart();
        test_drop_saturation();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
